// File: rtl/digit_entry_register.sv
// digit_entry_register: keypad digit shift register with backspace, clear, load, fill count and overflow pulse.
module digit_entry_register #(
  parameter int DIGIT_W = 4,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       push,
  input  logic [DIGIT_W-1:0]         digit,
  input  logic                       pop,
  input  logic                       clr,
  input  logic                       load,
  input  logic [DEPTH*DIGIT_W-1:0]   load_data,
  output logic [DEPTH*DIGIT_W-1:0]   Q,
  output logic [CW-1:0]              count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
);
  localparam int N = DEPTH * DIGIT_W;
  logic [N-1:0]  r_q;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic [N-1:0]  w_shl, w_shr, w_rep;
  logic          w_full, w_empty;
  assign w_full  = r_count == CW'(DEPTH);
  assign w_empty = r_count == '0;
  assign w_shl   = {r_q[N-DIGIT_W-1:0], digit};
  assign w_shr   = {{DIGIT_W{1'b0}}, r_q[N-1:DIGIT_W]};
  assign w_rep   = {r_q[N-1:DIGIT_W], digit};
  // push+pop on a non-empty register rewrites the newest digit; on empty it falls through to push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q     <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_ovf <= en && !clr && !load && push && !pop && w_full;
      if (en) begin
        if (clr) begin
          r_q     <= '0;
          r_count <= '0;
        end else if (load) begin
          r_q     <= load_data;
          r_count <= CW'(DEPTH);
        end else if (push && pop && !w_empty) begin
          r_q <= w_rep;
        end else if (push && !w_full) begin
          r_q     <= w_shl;
          r_count <= r_count + CW'(1);
        end else if (pop && !push && !w_empty) begin
          r_q     <= w_shr;
          r_count <= r_count - CW'(1);
        end
      end
    end
  end
  assign Q        = r_q;
  assign count    = r_count;
  assign full     = w_full;
  assign empty    = w_empty;
  assign overflow = r_ovf;
endmodule

// File: tb/tb_digit_entry_register.sv
// tb_digit_entry_register: randomized and directed stimulus against a digit-list model with a queued scoreboard.
module tb_digit_entry_register;
  localparam int W = 4;
  localparam int D = 4;
  typedef struct {
    logic [D*W-1:0] q;
    int             cnt;
    bit             full;
    bit             empty;
    bit             ovf;
  } exp_t;
  logic clk = 0, rst = 1, en = 0, push = 0, pop = 0, clr = 0, load = 0;
  logic [W-1:0]   digit = 0;
  logic [D*W-1:0] load_data = 0;
  logic [D*W-1:0] Q;
  logic [2:0]     count;
  logic           full, empty, overflow;
  int checks = 0, errors = 0;
  int m[$];
  bit m_ovf;
  exp_t sb[$];
  digit_entry_register #(.DIGIT_W(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .en(en), .push(push), .digit(digit), .pop(pop),
    .clr(clr), .load(load), .load_data(load_data), .Q(Q), .count(count),
    .full(full), .empty(empty), .overflow(overflow)
  );
  always #5 clk = ~clk;
  function automatic exp_t model_out();
    exp_t e;
    e.q = '0;
    for (int k = 0; k < D; k++) if (k < m.size()) e.q[k*W +: W] = W'(m[k]);
    e.cnt = m.size();
    e.full = m.size() == D;
    e.empty = m.size() == 0;
    e.ovf = m_ovf;
    return e;
  endfunction
  task automatic cmp(input exp_t e, input string name);
    checks++;
    if (Q !== e.q || int'(count) != e.cnt || full !== e.full || empty !== e.empty || overflow !== e.ovf) begin
      errors++;
      $display("FAIL %s: got Q=%h cnt=%0d full=%b empty=%b ovf=%b, want Q=%h cnt=%0d full=%b empty=%b ovf=%b",
               name, Q, count, full, empty, overflow, e.q, e.cnt, e.full, e.empty, e.ovf);
    end
  endtask
  always @(negedge clk) if (sb.size() != 0) cmp(sb.pop_front(), "scoreboard");
  task automatic step(input bit e, input bit pu, input bit po, input bit c, input bit l,
                      input logic [W-1:0] d, input logic [D*W-1:0] ld);
    @(negedge clk);
    en = e; push = pu; pop = po; clr = c; load = l; digit = d; load_data = ld;
    @(posedge clk);
    m_ovf = 0;
    if (e) begin
      if (c) m.delete();
      else if (l) begin
        m.delete();
        for (int k = 0; k < D; k++) m.push_back(int'(ld[k*W +: W]));
      end else if (pu && po && m.size() > 0) m[0] = int'(d);
      else if (pu) begin
        if (m.size() < D) m.push_front(int'(d));
        else m_ovf = 1;
      end else if (po && m.size() > 0) void'(m.pop_front());
    end
    sb.push_back(model_out());
  endtask
  task automatic async_reset();
    @(negedge clk);
    en = 0; push = 0; pop = 0; clr = 0; load = 0;
    #1 rst = 1;
    #1 m.delete(); m_ovf = 0;
    cmp(model_out(), "async_reset");
    rst = 0;
  endtask
  initial begin
    m_ovf = 0;
    #12 cmp(model_out(), "reset_state");
    @(negedge clk) rst = 0;
    for (int i = 1; i <= 4; i++) step(1, 1, 0, 0, 0, W'(i), 0);
    step(1, 1, 0, 0, 0, 9, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    repeat (3) step(1, 1, 0, 0, 0, 9, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 6, 0);
    repeat (5) step(1, 0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 3, 0);
    step(1, 1, 0, 0, 0, 4, 0);
    step(1, 1, 1, 0, 0, 7, 0);
    step(1, 0, 0, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 5, 0);
    step(1, 1, 0, 0, 1, 2, 16'hA5C3);
    step(1, 0, 0, 1, 1, 0, 16'h1234);
    step(1, 1, 0, 0, 0, 8, 0);
    step(0, 1, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 16'hFFFF);
    step(1, 1, 0, 0, 0, 2, 0);
    async_reset();
    for (int i = 0; i < 400; i++) begin
      if (i % 47 == 46) async_reset();
      else step($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3,
                $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
                W'($urandom_range(0, 15)), D*W'($urandom));
    end
    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
